// File: rtl/v_instr_queue.sv
// Vector-instruction decoupling FIFO between the scalar core and the vector scheduler.
// Optional macro V_QUEUE_BYPASS_EN enables zero-latency issue when the queue is empty.
module v_instr_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             v_instr_valid_i,
  input  logic [31:0]      v_instr_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      rs2_i,
  output logic             q_stall_o,
  output logic [31:0]      vector_instr_o,
  output logic [31:0]      rs1_o,
  output logic [31:0]      rs2_o,
  output logic             v_instr_valid_o,
  input  logic             vector_stall_i,
  output logic             q_vld_pending_o,
  output logic             q_vst_pending_o,
  output logic [CNT_W-1:0] q_count_o,
  output logic             q_overflow_o
);

  localparam int         PTR_W      = $clog2(DEPTH);
  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  logic [95:0]      entry_q [DEPTH];
  logic [1:0]       tag_q   [DEPTH];  // {is_load, is_store}
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, vld_cnt, vst_cnt;
  logic             overflow;

  logic        full, empty, push, pop, bypass;
  logic        in_load, in_store, head_load, head_store;
  logic [95:0] head_entry;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_load  = (v_instr_i[6:0] == OPC_VLOAD);
  assign in_store = (v_instr_i[6:0] == OPC_VSTORE);

`ifdef V_QUEUE_BYPASS_EN
  assign bypass = empty & v_instr_valid_i & ~vector_stall_i;
`else
  assign bypass = 1'b0;
`endif

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign push = v_instr_valid_i & ~full & ~bypass;
  assign pop  = ~empty & ~vector_stall_i;

  assign head_entry              = entry_q[rd_ptr];
  assign {head_load, head_store} = tag_q[rd_ptr];

  always_comb begin
    v_instr_valid_o = ~empty;
    vector_instr_o  = empty ? 32'h0 : head_entry[95:64];
    rs1_o           = empty ? 32'h0 : head_entry[63:32];
    rs2_o           = empty ? 32'h0 : head_entry[31:0];
`ifdef V_QUEUE_BYPASS_EN
    if (bypass) begin
      v_instr_valid_o = 1'b1;
      vector_instr_o  = v_instr_i;
      rs1_o           = rs1_i;
      rs2_o           = rs2_i;
    end
`endif
  end

  assign q_stall_o       = full;
  assign q_count_o       = count;
  assign q_vld_pending_o = (vld_cnt != '0);
  assign q_vst_pending_o = (vst_cnt != '0);
  assign q_overflow_o    = overflow;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CNT_W'(1);
      2'b01:   return cnt - CNT_W'(1);
      default: return cnt;
    endcase
  endfunction

  // NOTE: the entry array has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[wr_ptr] <= {v_instr_i, rs1_i, rs2_i};
      tag_q[wr_ptr]   <= {in_load, in_store};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      vld_cnt  <= '0;
      vst_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= next_cnt(count,   push,            pop);
      vld_cnt <= next_cnt(vld_cnt, push & in_load,  pop & head_load);
      vst_cnt <= next_cnt(vst_cnt, push & in_store, pop & head_store);
      if (v_instr_valid_i && full) overflow <= 1'b1;
    end
  end

endmodule
